// File: rtl/scanner_handoff.sv
// scanner_handoff: scanner byte FIFO with four-phase PIO handshake; SCANNER_OVF_CNT_EN adds ovf_count.
module scanner_handoff #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scan_valid,
    input  logic [7:0]               scan_data,
    output logic                     scan_ready,
    input  logic                     proc_ack,
    output logic [7:0]               out_of_scanner,
    output logic                     data_ready,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef SCANNER_OVF_CNT_EN
    ,
    output logic [7:0]               ovf_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, PRESENT, WAIT_LOW} state_t;
    state_t state, state_n;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, push, drop, pop, load;
    assign full = fifo_count == FULL;
    assign push = scan_valid && !full;
    assign drop = scan_valid && full;
    assign load = state == IDLE && fifo_count != '0 && !proc_ack;
    assign pop = state == PRESENT && proc_ack;
    assign scan_ready = !full;
    assign data_ready = state == PRESENT;
    always_comb begin
        state_n = state;
        state_n = load ? PRESENT : pop ? WAIT_LOW : (state == WAIT_LOW && !proc_ack) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= scan_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            out_of_scanner <= 8'h00;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            if (load) out_of_scanner <= mem[rd_ptr];
            // a drop in the same cycle as a clear keeps the flag set
            if (drop) overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end
`ifdef SCANNER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) ovf_count <= 8'h00;
        else if (overflow_clr) ovf_count <= {7'b0, drop};
        else if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
    end
`endif
endmodule

// File: tb/tb_scanner_handoff.sv
// tb_scanner_handoff: directed self-checking bench for scanner_handoff.
module tb_scanner_handoff;
    logic clk = 1'b0;
    logic reset, scan_valid, proc_ack, overflow_clr;
    logic [7:0] scan_data;
    logic scan_ready, data_ready, overflow;
    logic [7:0] out_of_scanner;
    logic [3:0] fifo_count;
    int checks = 0;
    int errors = 0;
`ifdef SCANNER_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif
    scanner_handoff #(.DEPTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .scan_valid(scan_valid),
        .scan_data(scan_data),
        .scan_ready(scan_ready),
        .proc_ack(proc_ack),
        .out_of_scanner(out_of_scanner),
        .data_ready(data_ready),
        .overflow(overflow),
        .overflow_clr(overflow_clr),
        .fifo_count(fifo_count)
`ifdef SCANNER_OVF_CNT_EN
        ,
        .ovf_count(ovf_count)
`endif
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] d);
        scan_valid = 1'b1;
        scan_data = d;
        tick();
        scan_valid = 1'b0;
    endtask
    task automatic handshake(input logic [7:0] exp);
        int n = 0;
        while (!data_ready && n < 20) begin
            tick();
            n++;
        end
        chk("hs_ready", data_ready, 1);
        chk("hs_byte", out_of_scanner, exp);
        proc_ack = 1'b1;
        tick();
        chk("hs_ack_low", data_ready, 0);
        proc_ack = 1'b0;
        tick();
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"}, out_of_scanner, 8'h00);
        chk({tag, "_dr"}, data_ready, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_cnt"}, fifo_count, 0);
        chk({tag, "_srdy"}, scan_ready, 1);
`ifdef SCANNER_OVF_CNT_EN
        chk({tag, "_ovfcnt"}, ovf_count, 0);
`endif
    endtask
    initial begin
        reset = 1'b1;
        scan_valid = 1'b0;
        scan_data = 8'h00;
        proc_ack = 1'b0;
        overflow_clr = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset = 1'b0;
        tick();
        // single byte
        push(8'hA5);
        chk("sb_cnt1", fifo_count, 1);
        chk("sb_dr_early", data_ready, 0);
        tick();
        chk("sb_dr", data_ready, 1);
        chk("sb_out", out_of_scanner, 8'hA5);
        proc_ack = 1'b1;
        tick();
        chk("sb_dr_ack", data_ready, 0);
        chk("sb_cnt0", fifo_count, 0);
        proc_ack = 1'b0;
        tick();
        tick();
        chk("sb_idle_dr", data_ready, 0);
        chk("sb_hold", out_of_scanner, 8'hA5);
        // burst
        for (int i = 1; i <= 5; i++) push(8'(i));
        chk("burst_cnt", fifo_count, 5);
        for (int i = 1; i <= 5; i++) handshake(8'(i));
        chk("burst_cnt_end", fifo_count, 0);
        chk("burst_dr_end", data_ready, 0);
        // overflow
        for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
        chk("ovf_cnt", fifo_count, 8);
        chk("ovf_srdy", scan_ready, 0);
        chk("ovf_flag", overflow, 1);
`ifdef SCANNER_OVF_CNT_EN
        chk("ovf_count2", ovf_count, 2);
`endif
        for (int i = 0; i < 8; i++) handshake(8'h10 + 8'(i));
        chk("ovf_drained", fifo_count, 0);
        chk("ovf_srdy_back", scan_ready, 1);
        chk("ovf_sticky", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
`ifdef SCANNER_OVF_CNT_EN
        chk("ovf_count_clr", ovf_count, 0);
`endif
        // full push+pop, with a simultaneous clear
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        chk("fp_full", fifo_count, 8);
        chk("fp_dr", data_ready, 1);
        chk("fp_out", out_of_scanner, 8'h20);
        chk("fp_ovf_pre", overflow, 0);
        proc_ack = 1'b1;
        scan_valid = 1'b1;
        scan_data = 8'h77;
        overflow_clr = 1'b1;
        tick();
        scan_valid = 1'b0;
        overflow_clr = 1'b0;
        chk("fp_cnt7", fifo_count, 7);
        chk("fp_ovf", overflow, 1);
        chk("fp_dr_low", data_ready, 0);
`ifdef SCANNER_OVF_CNT_EN
        chk("fp_ovfcnt1", ovf_count, 1);
`endif
        proc_ack = 1'b0;
        tick();
        for (int i = 1; i < 8; i++) handshake(8'h20 + 8'(i));
        chk("fp_cnt_end", fifo_count, 0);
        tick();
        chk("fp_no_77", data_ready, 0);
        // stale ack through reset release
        proc_ack = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        push(8'h3C);
        tick();
        tick();
        chk("stale_dr", data_ready, 0);
        chk("stale_cnt", fifo_count, 1);
        chk("stale_ovf", overflow, 0);
        proc_ack = 1'b0;
        tick();
        chk("stale_dr_up", data_ready, 1);
        chk("stale_out", out_of_scanner, 8'h3C);
        proc_ack = 1'b1;
        tick();
        chk("stale_cnt0", fifo_count, 0);
        proc_ack = 1'b0;
        tick();
        // reset mid-transfer
        push(8'h41);
        push(8'h42);
        push(8'h43);
        chk("mid_dr", data_ready, 1);
        chk("mid_cnt", fifo_count, 3);
        chk("mid_out", out_of_scanner, 8'h41);
        reset = 1'b1;
        tick();
        chk_reset_vals("mid");
        reset = 1'b0;
        tick();
        tick();
        chk("mid_after_dr", data_ready, 0);
        chk("mid_after_cnt", fifo_count, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scanner_handoff.md
# scanner_handoff

Upstream companion to the Nios II scanner input PIO. It accepts a byte stream from the scanner front end and buffers it in a small FIFO. It presents one byte at a time on `out_of_scanner`, which drives the PIO `in_port`. A four-phase level handshake with software (`data_ready` out via an input PIO, `proc_ack` in via an output PIO) paces delivery, so no byte is lost or read twice while the FIFO has room.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, 2..64.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `scan_valid`  in  1  qualifies `scan_data` for one cycle.
- `scan_data`  in  8  scanner byte.
- `scan_ready`  out  1  high when FIFO not full (advisory; scanner may ignore).
- `proc_ack`  in  1  software acknowledge level.
- `out_of_scanner`  out  8  presented byte, to PIO `in_port`.
- `data_ready`  out  1  `out_of_scanner` holds a valid, unacknowledged byte.
- `overflow`  out  1  sticky: a byte was dropped on full.
- `overflow_clr`  in  1  clears `overflow`.
- `fifo_count`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `ovf_count`  out  8  dropped-byte counter; exists only with `SCANNER_OVF_CNT_EN`.

## Operation
- **FIFO.** Circular buffer with read/write pointers and an occupancy counter. `scan_ready = (fifo_count != DEPTH)`.
- **Push.** `scan_valid` with FIFO not full writes `scan_data` at the write pointer.
- **Drop on full.** `scan_valid` with FIFO full discards the byte and sets `overflow`.
  - Full is evaluated on the pre-pop count. A push in the same cycle as a pop from a full FIFO is dropped.
- **Pop.** Occurs only on the handshake (PRESENT→WAIT_LOW).
- **Simultaneous push and pop** (not full): count unchanged, both pointers advance.
- **Pointer wrap.** Pointers wrap modulo DEPTH.
- **Handshake FSM states:**
  - IDLE: if `fifo_count != 0` and `proc_ack == 0`, load head into `out_of_scanner` → PRESENT. Otherwise stay.
  - PRESENT: `data_ready = 1`. When `proc_ack == 1`: pop, → WAIT_LOW.
  - WAIT_LOW: `data_ready = 0`. When `proc_ack == 0` → IDLE.
- **`proc_ack` high at reset release or in IDLE:** no load until it drops. This prevents a stale ack from consuming a byte.
- **`out_of_scanner` hold.** Keeps the last presented byte until the next load; it is never cleared except by reset.
- **`overflow_clr` vs. overflow event.** If `overflow_clr` and a drop occur in the same cycle, the set wins (`overflow` stays 1).
- **Reset mid-operation.** FIFO emptied, pointers 0, FSM → IDLE, any byte in flight lost.

## Timing
- **Reset values:** `out_of_scanner` 0x00, `data_ready` 0, `overflow` 0, `fifo_count` 0, `scan_ready` 1, `ovf_count` 0.
- **Outputs are registered.** `scan_ready` is decoded from the registered count.
- **Push into empty FIFO:**
  - `scan_valid` at edge N.
  - `fifo_count = 1` after edge N.
  - Load at edge N+1.
  - `data_ready = 1` after edge N+1 (1-cycle push-to-ready latency).
- **Ack path:**
  - `proc_ack` sampled high at edge M.
  - `data_ready = 0` and `fifo_count` decremented after edge M.
- **Back-to-back transfers.** The next byte is presented earliest one cycle after `proc_ack` is sampled low.
- **Software model:**
  1. Poll `data_ready == 1`.
  2. Read `out_of_scanner`.
  3. Write `proc_ack = 1`.
  4. Poll `data_ready == 0`.
  5. Write `proc_ack = 0`.

## Configuration
- **Macro:** `SCANNER_OVF_CNT_EN`.
- **Defined:**
  - Adds output port `ovf_count[7:0]`.
  - Increments once per dropped byte and saturates at 0xFF.
  - Cleared by `reset` or `overflow_clr`; a drop in the same cycle as a clear yields 1.
- **Undefined:** port and counter absent. The sticky `overflow` flag is unchanged in both builds.

## Test plan
- **Single byte:** push 0xA5 into empty FIFO → `data_ready` = 1 one cycle later, `out_of_scanner` = 0xA5. Ack high → `data_ready` = 0, `fifo_count` = 0. Ack low → FSM IDLE.
- **Burst:** push 0x01..0x05 on consecutive cycles, then handshake 5 times → bytes read in order 0x01..0x05, no duplicates, `fifo_count` ends 0.
- **Overflow:** DEPTH=8, push 10 bytes with no ack → `fifo_count` = 8, `scan_ready` = 0, `overflow` = 1, `ovf_count` = 2 (macro on). Drain → first 8 bytes delivered. `overflow_clr` → `overflow` = 0, `ovf_count` = 0.
- **Full push+pop:** FIFO full, pop and push 0x77 in the same cycle → 0x77 dropped, `fifo_count` = 7, `overflow` = 1.
- **Stale ack:** hold `proc_ack` = 1 through reset release, push 0x3C → `data_ready` stays 0. Drop `proc_ack` → `data_ready` = 1 one cycle later with 0x3C.
- **Reset mid-transfer:** assert `reset` in PRESENT with 3 bytes queued → next cycle all outputs at reset values, `fifo_count` = 0.
